cp_frame_decoder: RTL and testbench

Receives the byte stream from one control-protection (CP) link and validates fixed-length frames. It extracts the control word, modulation voltage target, cosine value and fast-lock flag. It is instantiated once per system (A and B), directly upstream of the A/B master/slave switch. Its outputs drive that switch's per-system inputs: control word, target voltage, cos-theta, fast-lock, frame-done pulse and checksum-error level.

---
 rtl/cp_link_pkg.sv | 35 +++
 rtl/cp_link_watchdog.sv | 51 +++++
 rtl/cp_frame_decoder.sv | 219 +++++++++++++++++++++
 tb/tb_cp_frame_decoder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cp_link_pkg
// Description : Shared constants, field layout and FSM encoding for the
//               control-protection link frame decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package cp_link_pkg;

  // Frame delimiters
  localparam logic [7:0] c_HDR0 = 8'hEB;
  localparam logic [7:0] c_HDR1 = 8'h90;

  // Payload geometry: byte offsets of each field within the 10-byte payload
  localparam int c_PAYLOAD_LEN = 10;
  localparam int c_OFF_CTRL    = 0;
  localparam int c_OFF_TVOL    = 2;
  localparam int c_OFF_COS     = 6;
  localparam int c_OFF_FLAGS   = 8;
  localparam int c_OFF_SEQ     = 9;

  // Default timing limits in clk_20M cycles
  localparam int c_BYTE_TIMEOUT = 200;     // 10 us
  localparam int c_LINK_TIMEOUT = 400000;  // 20 ms

  // Byte-level receive FSM encoding
  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CHK     = 2'd3
  } cp_state_t;

endpackage : cp_link_pkg
`default_nettype wire

// File: rtl/cp_link_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : cp_link_watchdog
// Description : Saturating link-silence counter. Raises o_link_err once no
//               accepted frame has been seen for LINK_TIMEOUT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module cp_link_watchdog
  import cp_link_pkg::*;
#(
  parameter int LINK_TIMEOUT = c_LINK_TIMEOUT
) (
  input  logic clk_20M,
  input  logic reset,
  input  logic i_clear,
  output logic o_link_err
);

  localparam int CNT_W = $clog2(LINK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(LINK_TIMEOUT);

  logic [CNT_W-1:0] r_cnt;
  logic             r_link_err;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Next count: a good frame restarts the window, otherwise count up and hold at the limit
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clear) begin
      w_cnt_nxt = '0;
    end else if (r_cnt != c_CNT_MAX) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  // Register the count and derive the error level from the value being loaded,
  // so the flag tracks the count in the same cycle
  always_ff @(posedge clk_20M) begin
    if (reset) begin
      r_cnt      <= '0;
      r_link_err <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_link_err <= (w_cnt_nxt >= c_CNT_MAX);
    end
  end

  assign o_link_err = r_link_err;

endmodule : cp_link_watchdog
`default_nettype wire

// File: rtl/cp_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module      : cp_frame_decoder
// Description : Validates 13-byte CP link frames (2 header, 10 payload,
//               1 checksum), publishes the fields of each good frame and
//               tracks checksum errors, byte timeouts and link silence.
// Revision    : 1.0 - initial release
// ============================================================================
module cp_frame_decoder
  import cp_link_pkg::*;
#(
  parameter logic [7:0] HDR0         = c_HDR0,
  parameter logic [7:0] HDR1         = c_HDR1,
  parameter int         BYTE_TIMEOUT = c_BYTE_TIMEOUT,
  parameter int         LINK_TIMEOUT = c_LINK_TIMEOUT
) (
  input  logic        clk_20M,
  input  logic        reset,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic [15:0] o_CtrlWord,
  output logic [31:0] o_TargetVol,
  output logic [15:0] o_CosThet,
  output logic        o_fastlock,
  output logic [7:0]  o_seq,
  output logic        o_rd_int,
  output logic        o_sumerr,
  output logic        o_link_err,
  output logic [15:0] o_err_cnt
);

  // r_gap holds the number of idle cycles already elapsed since the last
  // byte; the current cycle is the BYTE_TIMEOUT-th idle one when it equals
  // BYTE_TIMEOUT-1, so it never needs to hold BYTE_TIMEOUT itself.
  localparam int GAP_W    = $clog2(BYTE_TIMEOUT);
  localparam int SHADOW_W = c_PAYLOAD_LEN * 8;

  localparam logic [GAP_W-1:0] c_GAP_LAST = GAP_W'(BYTE_TIMEOUT - 1);
  localparam logic [3:0]       c_LAST_IDX = 4'(c_PAYLOAD_LEN - 1);

  // Payload is shifted in MSB first, so byte k ends up at the top end minus k bytes
  localparam int c_CTRL_LSB  = (c_PAYLOAD_LEN - c_OFF_CTRL  - 2) * 8;
  localparam int c_TVOL_LSB  = (c_PAYLOAD_LEN - c_OFF_TVOL  - 4) * 8;
  localparam int c_COS_LSB   = (c_PAYLOAD_LEN - c_OFF_COS   - 2) * 8;
  localparam int c_FLAGS_LSB = (c_PAYLOAD_LEN - c_OFF_FLAGS - 1) * 8;
  localparam int c_SEQ_LSB   = (c_PAYLOAD_LEN - c_OFF_SEQ   - 1) * 8;

  cp_state_t            r_state;
  cp_state_t            w_state_nxt;

  logic [GAP_W-1:0]     r_gap;
  logic [3:0]           r_idx;
  logic [7:0]           r_sum;
  logic [SHADOW_W-1:0]  r_shadow;

  logic [15:0]          r_ctrl_word;
  logic [31:0]          r_target_vol;
  logic [15:0]          r_cos_thet;
  logic                 r_fastlock;
  logic [7:0]           r_seq;
  logic                 r_rd_int;
  logic                 r_sumerr;
  logic [15:0]          r_err_cnt;

  logic                 w_gap_exp;
  logic                 w_start;
  logic                 w_byte_acc;
  logic                 w_chk_good;
  logic                 w_chk_bad;
  logic                 w_timeout;
  logic                 w_err_event;

  assign w_gap_exp   = (r_gap == c_GAP_LAST);
  assign w_err_event = w_chk_bad | w_timeout;

  // FSM state register
  always_ff @(posedge clk_20M) begin
    if (reset) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-byte strobes; a byte arriving on the expiry cycle takes priority
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_byte_acc  = 1'b0;
    w_chk_good  = 1'b0;
    w_chk_bad   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_HUNT: begin
        if (i_rx_valid && (i_rx_data == HDR0)) begin
          w_state_nxt = ST_HDR;
        end
      end
      ST_HDR: begin
        if (i_rx_valid) begin
          if (i_rx_data == HDR1) begin
            w_state_nxt = ST_PAYLOAD;
            w_start     = 1'b1;
          end else if (i_rx_data == HDR0) begin
            w_state_nxt = ST_HDR;
          end else begin
            w_state_nxt = ST_HUNT;
          end
        end else if (w_gap_exp) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_HUNT;
        end
      end
      ST_PAYLOAD: begin
        if (i_rx_valid) begin
          w_byte_acc = 1'b1;
          if (r_idx == c_LAST_IDX) begin
            w_state_nxt = ST_CHK;
          end
        end else if (w_gap_exp) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_HUNT;
        end
      end
      ST_CHK: begin
        if (i_rx_valid) begin
          if (i_rx_data == r_sum) begin
            w_chk_good = 1'b1;
          end else begin
            w_chk_bad = 1'b1;
          end
          w_state_nxt = ST_HUNT;
        end else if (w_gap_exp) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_HUNT;
        end
      end
      default: begin
        w_state_nxt = ST_HUNT;
      end
    endcase
  end

  // Inter-byte gap counter, payload index, running sum and shadow capture
  always_ff @(posedge clk_20M) begin
    if (reset) begin
      r_gap    <= '0;
      r_idx    <= '0;
      r_sum    <= '0;
      r_shadow <= '0;
    end else begin
      if (i_rx_valid || (w_state_nxt == ST_HUNT)) begin
        r_gap <= '0;
      end else begin
        r_gap <= r_gap + GAP_W'(1);
      end

      if (w_start) begin
        r_idx <= '0;
        r_sum <= '0;
      end else if (w_byte_acc) begin
        r_idx    <= r_idx + 4'd1;
        r_sum    <= r_sum + i_rx_data;
        r_shadow <= {r_shadow[SHADOW_W-9:0], i_rx_data};
      end
    end
  end

  // Output registers: only a checksum-clean frame moves the published fields
  always_ff @(posedge clk_20M) begin
    if (reset) begin
      r_ctrl_word  <= '0;
      r_target_vol <= '0;
      r_cos_thet   <= '0;
      r_fastlock   <= 1'b0;
      r_seq        <= '0;
      r_rd_int     <= 1'b0;
      r_sumerr     <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_rd_int <= w_chk_good;

      if (w_chk_good) begin
        r_ctrl_word  <= r_shadow[c_CTRL_LSB  +: 16];
        r_target_vol <= r_shadow[c_TVOL_LSB  +: 32];
        r_cos_thet   <= r_shadow[c_COS_LSB   +: 16];
        r_fastlock   <= r_shadow[c_FLAGS_LSB];
        r_seq        <= r_shadow[c_SEQ_LSB   +: 8];
        r_sumerr     <= 1'b0;
      end else if (w_chk_bad) begin
        r_sumerr <= 1'b1;
      end

      if (w_err_event && (r_err_cnt != 16'hFFFF)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  cp_link_watchdog #(
    .LINK_TIMEOUT (LINK_TIMEOUT)
  ) u_link_watchdog (
    .clk_20M    (clk_20M),
    .reset      (reset),
    .i_clear    (w_chk_good),
    .o_link_err (o_link_err)
  );

  assign o_CtrlWord  = r_ctrl_word;
  assign o_TargetVol = r_target_vol;
  assign o_CosThet   = r_cos_thet;
  assign o_fastlock  = r_fastlock;
  assign o_seq       = r_seq;
  assign o_rd_int    = r_rd_int;
  assign o_sumerr    = r_sumerr;
  assign o_err_cnt   = r_err_cnt;

endmodule : cp_frame_decoder
`default_nettype wire

// File: tb/tb_cp_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cp_frame_decoder
// Description : Self-checking bench for cp_frame_decoder with a frame-level
//               reference model and randomized payloads.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cp_frame_decoder;

  localparam int c_BYTE_TIMEOUT = 200;
  localparam int c_LINK_TIMEOUT = 3000;
  localparam logic [7:0] c_H0 = 8'hEB;
  localparam logic [7:0] c_H1 = 8'h90;

  logic        clk_20M    = 1'b0;
  logic        reset      = 1'b1;
  logic [7:0]  i_rx_data  = 8'h00;
  logic        i_rx_valid = 1'b0;
  logic [15:0] o_CtrlWord;
  logic [31:0] o_TargetVol;
  logic [15:0] o_CosThet;
  logic        o_fastlock;
  logic [7:0]  o_seq;
  logic        o_rd_int;
  logic        o_sumerr;
  logic        o_link_err;
  logic [15:0] o_err_cnt;

  always #25 clk_20M = ~clk_20M;

  cp_frame_decoder #(
    .BYTE_TIMEOUT (c_BYTE_TIMEOUT),
    .LINK_TIMEOUT (c_LINK_TIMEOUT)
  ) dut (
    .clk_20M     (clk_20M),
    .reset       (reset),
    .i_rx_data   (i_rx_data),
    .i_rx_valid  (i_rx_valid),
    .o_CtrlWord  (o_CtrlWord),
    .o_TargetVol (o_TargetVol),
    .o_CosThet   (o_CosThet),
    .o_fastlock  (o_fastlock),
    .o_seq       (o_seq),
    .o_rd_int    (o_rd_int),
    .o_sumerr    (o_sumerr),
    .o_link_err  (o_link_err),
    .o_err_cnt   (o_err_cnt)
  );

  int vectors     = 0;
  int miscompares = 0;
  int rd_pulses   = 0;
  int rd_mark     = 0;

  // Every cycle with o_rd_int high is one pulse cycle
  always @(posedge clk_20M) if (o_rd_int) rd_pulses <= rd_pulses + 1;

  // Reference model state: what the outputs should show right now
  logic [7:0]  g_pl [0:9];
  logic [15:0] m_ctrl;
  logic [31:0] m_tv;
  logic [15:0] m_cos;
  logic        m_fl;
  logic [7:0]  m_seq;
  logic        m_sumerr;
  int          m_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_ctrl"},   64'(o_CtrlWord),  64'(m_ctrl));
    check({tag, "_tvol"},   64'(o_TargetVol), 64'(m_tv));
    check({tag, "_cos"},    64'(o_CosThet),   64'(m_cos));
    check({tag, "_fl"},     64'(o_fastlock),  64'(m_fl));
    check({tag, "_seq"},    64'(o_seq),       64'(m_seq));
    check({tag, "_sumerr"}, 64'(o_sumerr),    64'(m_sumerr));
    check({tag, "_errcnt"}, 64'(o_err_cnt),   64'(m_err));
  endtask

  function automatic logic [7:0] model_chk();
    int s = 0;
    for (int i = 0; i < 10; i++) s += int'(g_pl[i]);
    return 8'(s % 256);
  endfunction

  task automatic model_reset();
    m_ctrl = '0; m_tv = '0; m_cos = '0; m_fl = 1'b0; m_seq = '0;
    m_sumerr = 1'b0; m_err = 0;
  endtask

  task automatic model_accept();
    m_ctrl   = {g_pl[0], g_pl[1]};
    m_tv     = {g_pl[2], g_pl[3], g_pl[4], g_pl[5]};
    m_cos    = {g_pl[6], g_pl[7]};
    m_fl     = g_pl[8][0];
    m_seq    = g_pl[9];
    m_sumerr = 1'b0;
  endtask

  task automatic fill_random(input bit no_hdr);
    for (int i = 0; i < 10; i++) begin
      g_pl[i] = 8'($urandom);
      if (no_hdr && g_pl[i] == c_H0) g_pl[i] = 8'h5A;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(posedge clk_20M); #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk_20M);
      #1;
    end
  endtask

  // Sends header, payload g_pl and checksum (+delta); optional stall after
  // payload byte stall_idx. A stall long enough to time out ends the frame.
  task automatic send_frame(input logic [7:0] chk_delta, input int stall_idx,
                            input int stall_len, input int max_gap);
    logic [7:0] chk;
    chk = model_chk() + chk_delta;
    rd_mark = rd_pulses;
    send_byte(c_H0);
    idle(int'($urandom_range(max_gap, 0)));
    send_byte(c_H1);
    for (int i = 0; i < 10; i++) begin
      idle(int'($urandom_range(max_gap, 0)));
      send_byte(g_pl[i]);
      if (i == stall_idx) begin
        idle(stall_len);
        if (stall_len >= c_BYTE_TIMEOUT) return;
      end
    end
    idle(int'($urandom_range(max_gap, 0)));
    send_byte(chk);
  endtask

  // Called in the cycle right after the checksum strobe
  task automatic expect_good(input string tag);
    model_accept();
    check({tag, "_rd"}, 64'(o_rd_int), 64'd1);
    check({tag, "_link"}, 64'(o_link_err), 64'd0);
    check_outputs(tag);
    @(posedge clk_20M); #1;
    check({tag, "_rd_off"}, 64'(o_rd_int), 64'd0);
    check({tag, "_pulses"}, 64'(rd_pulses - rd_mark), 64'd1);
  endtask

  task automatic expect_bad(input string tag);
    m_sumerr = 1'b1;
    m_err++;
    check({tag, "_rd"}, 64'(o_rd_int), 64'd0);
    check_outputs(tag);
    @(posedge clk_20M); #1;
    check({tag, "_pulses"}, 64'(rd_pulses - rd_mark), 64'd0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk_20M);
    #1;
    check_outputs("reset");
    check("reset_rd", 64'(o_rd_int), 64'd0);
    check("reset_link", 64'(o_link_err), 64'd0);
    reset = 1'b0;
    idle(2);

    // Reference frame with known field values
    g_pl = '{8'h01, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h0F, 8'hA0, 8'h01, 8'h05};
    send_frame(8'h00, -1, 0, 0);
    check("fix_ctrl", 64'(o_CtrlWord),  64'h0100);
    check("fix_tvol", 64'(o_TargetVol), 64'h12345678);
    check("fix_cos",  64'(o_CosThet),   64'h0FA0);
    check("fix_fl",   64'(o_fastlock),  64'd1);
    check("fix_seq",  64'(o_seq),       64'h05);
    expect_good("fix");

    // Same payload with a corrupted checksum, then a clean frame
    send_frame(8'h01, -1, 0, 0);
    expect_bad("badchk");
    idle(3);
    fill_random(1'b0);
    send_frame(8'h00, -1, 0, 2);
    expect_good("after_bad");

    // Resync on a doubled first header byte
    fill_random(1'b0);
    send_byte(c_H0);
    send_frame(8'h00, -1, 0, 1);
    expect_good("resync");

    // Broken header: silently ignored
    fill_random(1'b1);
    rd_mark = rd_pulses;
    send_byte(c_H0);
    send_byte(8'h55);
    send_byte(c_H1);
    for (int i = 0; i < 10; i++) send_byte(g_pl[i]);
    send_byte(8'h00);
    idle(3);
    check("badhdr_pulses", 64'(rd_pulses - rd_mark), 64'd0);
    check_outputs("badhdr");

    // Gap just below the byte timeout is tolerated
    fill_random(1'b0);
    send_frame(8'h00, 4, c_BYTE_TIMEOUT - 1, 0);
    expect_good("gap199");

    // Gap reaching the byte timeout aborts the frame
    fill_random(1'b0);
    send_frame(8'h00, 4, c_BYTE_TIMEOUT, 0);
    m_err++;
    check_outputs("gap200");
    check("gap200_pulses", 64'(rd_pulses - rd_mark), 64'd0);
    fill_random(1'b0);
    send_frame(8'h00, -1, 0, 0);
    expect_good("after_gap");

    // Randomized mix of good and corrupted frames
    for (int k = 0; k < 10; k++) begin
      logic [7:0] delta;
      fill_random(1'b0);
      delta = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
      send_frame(delta, -1, 0, 3);
      if (delta == 8'h00) expect_good("rand_good");
      else                expect_bad("rand_bad");
      idle(int'($urandom_range(10, 0)));
    end

    // Link watchdog: silence after a good frame (we are one cycle past o_rd_int)
    fill_random(1'b0);
    send_frame(8'h00, -1, 0, 0);
    expect_good("pre_link");
    idle(c_LINK_TIMEOUT - 2);
    check("link_below", 64'(o_link_err), 64'd0);
    idle(1);
    check("link_at", 64'(o_link_err), 64'd1);
    idle(50);
    check("link_hold", 64'(o_link_err), 64'd1);
    fill_random(1'b0);
    send_frame(8'h00, -1, 0, 0);
    expect_good("link_clear");

    // Reset in the middle of a frame
    fill_random(1'b1);
    rd_mark = rd_pulses;
    send_byte(c_H0);
    send_byte(c_H1);
    for (int i = 0; i < 7; i++) send_byte(g_pl[i]);
    reset = 1'b1;
    @(posedge clk_20M); #1;
    model_reset();
    check_outputs("midreset");
    check("midreset_rd", 64'(o_rd_int), 64'd0);
    check("midreset_link", 64'(o_link_err), 64'd0);
    reset = 1'b0;
    for (int i = 7; i < 10; i++) send_byte(g_pl[i]);
    send_byte(model_chk() == c_H0 ? 8'h00 : model_chk());
    idle(3);
    check("midreset_pulses", 64'(rd_pulses - rd_mark), 64'd0);
    check_outputs("midreset_tail");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_cp_frame_decoder
`default_nettype wire
